muldiv_sequencer: RTL
=====================

# muldiv_sequencer

Iterative multiply/divide unit and its sequencer for the execute stage; implements the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) on a single shared 64-bit shift/accumulate datapath. It accepts one operation from EX and holds the pipeline via `Stall` while iterating. It presents a registered result with a one-cycle `done` strobe, which the EX result mux selects over `ALUResult`. It sits beside the ALU and is fed the same `SrcA`/`SrcB` operands.

## Interface
- `XLEN`, 32: operand/result width; only 32 is supported.
- `clk`  in  1  sole clock; rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  EX holds a valid M-extension instruction. Held high until the instruction leaves EX.
- `funct3`  in  3  operation select, encoded as per RV32M.
- `SrcA`, `SrcB`  in  32 each  rs1/rs2 operands; sampled only on acceptance.
- `flush`  in  1  kill the in-flight operation (branch/jump redirect).
- `Stall`  out  1  freeze IF/ID/EX. Combinational: `(state==IDLE && start && !flush) || state==CALC`.
- `busy`  out  1  high when `state != IDLE`.
- `done`  out  1  high for exactly one cycle, in DONE.
- `Result`  out  32  registered; valid in DONE; held until the next acceptance.

## Operation
- **States:** IDLE, CALC, DONE.
- **Acceptance:** `start && !flush` in IDLE. Latch the operand magnitudes, the sign-fix flags and `funct3`; clear `count`.
- **Transitions from IDLE:**
  - Special division cases go IDLE→DONE.
  - All other operations go IDLE→CALC.
- **Transitions from CALC:** stay while `count != 31`. At `count == 31`, apply the sign fixup, load `Result`, and go to DONE.
- **Transitions from DONE:** always go to IDLE. `start` is ignored in DONE, because it is still high for the completing instruction.
- **Multiply:**
  - Compute the unsigned 32×32 product by shift-add over 32 iterations on a 64-bit accumulator.
  - Negate the product if the operand signs differ. MULH treats both operands as signed, MULHSU treats A as signed and B as unsigned, and MULHU and MUL treat both as unsigned for sign purposes.
  - MUL returns product[31:0]; the MULH variants return product[63:32].
- **Divide:**
  - Unsigned restoring division on magnitudes, one quotient bit per iteration.
  - DIV: the quotient is negated when the signs differ.
  - REM: the remainder takes the sign of the dividend.
- **Special cases (no iteration):**
  - Divisor 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return the dividend.
  - DIV with 0x80000000 / 0xFFFFFFFF returns 0x80000000; REM returns 0.
- **Flush:** in any state, the next state is IDLE, `done` is not raised, `Result` is unchanged, and `Stall` drops in that same cycle. Flush takes priority over acceptance and over CALC→DONE.
- **Width rules:** all internal arithmetic is unsigned. The accumulator is 64 bits, the divide partial remainder is 33 bits, and `count` is 5 bits (wraps 31→0, unused after the exit).

## Timing
- **Reset values** (synchronous; state when `rst_n==0` at an edge):
  - state = IDLE, `count` = 0, `Result` = 0.
  - `done` = 0, `busy` = 0.
  - `Stall` = 0, provided `start` is low.
- **Normal latency:** acceptance at edge k → CALC during cycles k+1…k+32 → DONE in cycle k+33 (`done`=1, `Stall`=0) → the instruction leaves EX at edge k+34.
- **Special-case latency:** DONE in cycle k+1.
- **Back-to-back operations:** a new operation can be accepted in the cycle after DONE.
- **Reset mid-operation:** behaves like flush, and additionally clears `Result`.

## Structure
- **Additions to `Pkg`:**
  - funct3 constants MUL=0 through REMU=7.
  - `muldiv_state_t` enum (IDLE, CALC, DONE).
  - `MULDIV_ITERS = 32`.
- **One sub-module, `muldiv_step`:** combinational single iteration.
  - Inputs: accumulator, operand, op class.
  - Output: next accumulator.
  - Function: shift-add for multiply, compare/subtract/shift for divide.
- **This module:** FSM, counter, sign logic and special-case detection.

## Test plan
- MUL 7 × 0xFFFFFFFD → `Result` 0xFFFFFFEB; `done` exactly 33 cycles after acceptance; `Stall` high from the acceptance cycle through cycle 32.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD; REM of the same operands → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- DIVU 5 / 0 → 0xFFFFFFFF; REM 5 / 0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0. Each completes with `done` one cycle after acceptance.
- Flush in CALC at `count`=10:
  - Next cycle is IDLE with no `done` and `Result` unchanged.
  - A following MUL 3×4 is accepted and returns 12.
- `rst_n` low mid-CALC → IDLE with `Result` 0.
- `start` held through DONE → no second acceptance.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 encodings, FSM state type and iteration count.
package muldiv_sequencer_pkg;

    localparam int unsigned MULDIV_ITERS = 32;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } muldiv_state_t;

    typedef enum logic {
        OP_MUL,
        OP_DIV
    } muldiv_class_t;

endpackage

// File: rtl/muldiv_sequencer_step.sv
// One combinational iteration of the shared datapath: LSB-first shift-add
// for multiply, restoring compare/subtract/shift for divide.
module muldiv_step
    import muldiv_sequencer_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   operand,
    input  muldiv_class_t     op_class,
    output logic [2*XLEN-1:0] acc_next
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   rem_shift;
    logic [XLEN-1:0] diff;

    always_comb begin
        sum       = '0;
        rem_shift = '0;
        diff      = '0;
        acc_next  = acc;
        if (op_class == OP_MUL) begin
            // Upper half accumulates; multiplier bits shift out of the low half.
            sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
            acc_next = {sum, acc[XLEN-1:1]};
        end else begin
            // Upper half is the partial remainder, low half collects quotient bits.
            rem_shift = acc[2*XLEN-1:XLEN-1];
            diff      = rem_shift[XLEN-1:0] - operand;
            if (rem_shift >= {1'b0, operand}) begin
                acc_next = {diff, acc[XLEN-2:0], 1'b1};
            end else begin
                acc_next = {acc[2*XLEN-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: accepts one op from EX, stalls the
// pipeline while iterating, and presents a registered result with a done strobe.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic            flush,
    output logic            Stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] Result
);

    localparam int unsigned CW = $clog2(MULDIV_ITERS);
    localparam logic [CW-1:0] LAST_COUNT = CW'(MULDIV_ITERS - 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_t     state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic            is_div, a_signed, b_signed, a_neg, b_neg;
    logic            div_by_zero, div_overflow;
    logic [XLEN-1:0] a_mag, b_mag, special_res;

    logic [2*XLEN-1:0] acc_step, prod_fix;
    logic [XLEN-1:0]   quot, rem, final_res;

    always_comb begin
        is_div       = funct3[2];
        a_signed     = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                       (funct3 == F3_DIV)  || (funct3 == F3_REM);
        b_signed     = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
        a_neg        = a_signed && SrcA[XLEN-1];
        b_neg        = b_signed && SrcB[XLEN-1];
        a_mag        = a_neg ? -SrcA : SrcA;
        b_mag        = b_neg ? -SrcB : SrcB;
        div_by_zero  = is_div && (SrcB == '0);
        div_overflow = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                       (SrcA == INT_MIN) && (SrcB == '1);
        if (funct3[1]) begin
            special_res = div_by_zero ? SrcA : '0;
        end else begin
            special_res = div_by_zero ? '1 : INT_MIN;
        end
    end

    muldiv_step #(
        .XLEN(XLEN)
    ) u_step (
        .acc      (acc_q),
        .operand  (opnd_q),
        .op_class (muldiv_class_t'(funct3_q[2])),
        .acc_next (acc_step)
    );

    // Sign fixup applied to the last iteration's output so Result loads on the exit edge.
    always_comb begin
        prod_fix = neg_q ? -acc_step : acc_step;
        quot     = acc_step[XLEN-1:0];
        rem      = acc_step[2*XLEN-1:XLEN];
        case (funct3_q)
            F3_MUL:           final_res = prod_fix[XLEN-1:0];
            F3_DIV, F3_DIVU:  final_res = neg_q ? -quot : quot;
            F3_REM, F3_REMU:  final_res = neg_q ? -rem : rem;
            default:          final_res = prod_fix[2*XLEN-1:XLEN];
        endcase
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        funct3_d = funct3_q;
        neg_d    = neg_q;
        result_d = result_q;
        Stall    = 1'b0;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        Stall    = 1'b1;
                        funct3_d = funct3;
                        neg_d    = funct3[1] && is_div ? a_neg : (a_neg ^ b_neg);
                        count_d  = '0;
                        opnd_d   = is_div ? b_mag : a_mag;
                        acc_d    = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
                        if (div_by_zero || div_overflow) begin
                            result_d = special_res;
                            state_d  = DONE;
                        end else begin
                            state_d  = CALC;
                        end
                    end
                end
                CALC: begin
                    Stall   = 1'b1;
                    acc_d   = acc_step;
                    count_d = count_q + 1'b1;
                    if (count_q == LAST_COUNT) begin
                        result_d = final_res;
                        state_d  = DONE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            funct3_q <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            funct3_q <= funct3_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign Result = result_q;

endmodule
